// File: rtl/blram_pkg.sv
// Shared types and defaults for the block-RAM copy engine and its address generators.
package blram_pkg;

    localparam int ADDR_LEN_DEF  = 14;
    localparam int MEM_DEPTH_DEF = 16384;
    localparam int WORD_W        = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_LAT  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/blram_copy_addr_gen.sv
// Word-address walker for one side of a copy: loads base(+offset) and steps up or down by one,
// wrapping modulo 2**ADDR_LEN. o_addr is the address selected for this cycle's edge.
module blram_copy_addr_gen
    import blram_pkg::*;
#(
    parameter int ADDR_LEN = ADDR_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [ADDR_LEN-1:0] i_base,
    input  logic [ADDR_LEN-1:0] i_offset,
    input  logic                i_down,
    input  logic                i_step,
    output logic [ADDR_LEN-1:0] o_addr
);

    localparam logic [ADDR_LEN-1:0] L_ONE = {{(ADDR_LEN-1){1'b0}}, 1'b1};

    logic [ADDR_LEN-1:0] r_addr;
    logic                r_down;

    // Next address: a descending walk starts at the top of the block, so the offset applies only then.
    always_comb begin
        o_addr = r_addr;
        if (i_load) begin
            if (i_down) begin
                o_addr = i_base + i_offset;
            end else begin
                o_addr = i_base;
            end
        end else if (i_step) begin
            if (r_down) begin
                o_addr = r_addr - L_ONE;
            end else begin
                o_addr = r_addr + L_ONE;
            end
        end else begin
            o_addr = r_addr;
        end
    end

    // Current address and latched direction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= {ADDR_LEN{1'b0}};
            r_down <= 1'b0;
        end else begin
            r_addr <= o_addr;
            if (i_load) begin
                r_down <= i_down;
            end else begin
                r_down <= r_down;
            end
        end
    end

endmodule

// File: rtl/blram_copy_engine.sv
// memmove-style word copy engine mastering a single-port, 1-cycle-latency block RAM.
// Optional feature: define BLRAM_COPY_SUM_EN to add the o_sum checksum of written words.
module blram_copy_engine
    import blram_pkg::*;
#(
    parameter int ADDR_LEN  = ADDR_LEN_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [ADDR_LEN-1:0] i_src,
    input  logic [ADDR_LEN-1:0] i_dst,
    input  logic [ADDR_LEN:0]   i_len,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_ram_we,
    output logic [ADDR_LEN-1:0] o_ram_addr,
    output logic [WORD_W-1:0]   o_ram_wdata,
`ifdef BLRAM_COPY_SUM_EN
    output logic [WORD_W-1:0]   o_sum,
`endif
    input  logic [WORD_W-1:0]   i_ram_rdata
);

    localparam logic [ADDR_LEN:0]   L_DEPTH   = MEM_DEPTH[ADDR_LEN:0];
    localparam logic [ADDR_LEN:0]   L_REM_ONE = {{ADDR_LEN{1'b0}}, 1'b1};
    localparam logic [ADDR_LEN-1:0] L_ONE     = {{(ADDR_LEN-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [ADDR_LEN:0]   r_rem;
    logic [ADDR_LEN:0]   w_len_eff;
    logic [ADDR_LEN-1:0] w_off;
    logic                w_down;
    logic                w_accept;
    logic                w_step;
    logic [ADDR_LEN-1:0] w_src_addr;
    logic [ADDR_LEN-1:0] w_dst_addr;

    // Length clamp to the RAM depth.
    always_comb begin
        if (i_len > L_DEPTH) begin
            w_len_eff = L_DEPTH;
        end else begin
            w_len_eff = i_len;
        end
    end

    // A full-depth length has zero low bits, so len-1 wraps to the last word as required.
    assign w_off    = w_len_eff[ADDR_LEN-1:0] - L_ONE;
    assign w_down   = (i_dst > i_src);
    assign w_accept = (r_state == ST_IDLE) && i_start;
    assign w_step   = (r_state == ST_WR);

    blram_copy_addr_gen #(.ADDR_LEN(ADDR_LEN)) u_src_gen (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_base   (i_src),
        .i_offset (w_off),
        .i_down   (w_down),
        .i_step   (w_step),
        .o_addr   (w_src_addr)
    );

    blram_copy_addr_gen #(.ADDR_LEN(ADDR_LEN)) u_dst_gen (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_base   (i_dst),
        .i_offset (w_off),
        .i_down   (w_down),
        .i_step   (w_step),
        .o_addr   (w_dst_addr)
    );

    // Copy sequencer with registered RAM-side and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_rem       <= {(ADDR_LEN+1){1'b0}};
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_ram_we    <= 1'b0;
            o_ram_addr  <= {ADDR_LEN{1'b0}};
            o_ram_wdata <= {WORD_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    o_done   <= 1'b0;
                    o_ram_we <= 1'b0;
                    if (i_start) begin
                        r_rem <= w_len_eff;
                        if (w_len_eff != {(ADDR_LEN+1){1'b0}}) begin
                            r_state    <= ST_RD;
                            o_busy     <= 1'b1;
                            o_ram_addr <= w_src_addr;
                        end else begin
                            r_state <= ST_DONE;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    r_state <= ST_LAT;
                end
                ST_LAT: begin
                    // Read data for the address held since RD is valid now.
                    r_state     <= ST_WR;
                    o_ram_addr  <= w_dst_addr;
                    o_ram_we    <= 1'b1;
                    o_ram_wdata <= i_ram_rdata;
                end
                ST_WR: begin
                    o_ram_we <= 1'b0;
                    r_rem    <= r_rem - L_REM_ONE;
                    if (r_rem == L_REM_ONE) begin
                        r_state <= ST_DONE;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                    end else begin
                        r_state    <= ST_RD;
                        o_ram_addr <= w_src_addr;
                    end
                end
                ST_DONE: begin
                    o_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    o_busy   <= 1'b0;
                    o_done   <= 1'b0;
                    o_ram_we <= 1'b0;
                end
            endcase
        end
    end

`ifdef BLRAM_COPY_SUM_EN
    // Running checksum of every word written; held from DONE until the next acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_sum <= {WORD_W{1'b0}};
        end else if (w_accept) begin
            o_sum <= {WORD_W{1'b0}};
        end else if (r_state == ST_WR) begin
            o_sum <= o_sum + o_ram_wdata;
        end else begin
            o_sum <= o_sum;
        end
    end
`endif

endmodule

// File: tb/tb_blram_copy_engine.sv
// Self-checking bench: engine paired with a behavioural RAM, checked against a memmove reference.
module tb_blram_copy_engine;

    localparam int AL = 14;
    localparam int D  = 16384;

    logic          clk;
    logic          rst;
    logic          i_start;
    logic [AL-1:0] i_src;
    logic [AL-1:0] i_dst;
    logic [AL:0]   i_len;
    logic          o_busy;
    logic          o_done;
    logic          o_ram_we;
    logic [AL-1:0] o_ram_addr;
    logic [31:0]   o_ram_wdata;
    logic [31:0]   i_ram_rdata;
`ifdef BLRAM_COPY_SUM_EN
    logic [31:0]   o_sum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    blram_copy_engine #(.ADDR_LEN(AL), .MEM_DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_src       (i_src),
        .i_dst       (i_dst),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_ram_we    (o_ram_we),
        .o_ram_addr  (o_ram_addr),
        .o_ram_wdata (o_ram_wdata),
`ifdef BLRAM_COPY_SUM_EN
        .o_sum       (o_sum),
`endif
        .i_ram_rdata (i_ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port RAM with registered read, plus a backdoor used only while the engine is idle.
    logic [31:0]   mem       [0:D-1];
    logic [31:0]   model_mem [0:D-1];
    logic          bd_we;
    logic          bd_fill;
    logic [AL-1:0] bd_addr;
    logic [31:0]   bd_data;
    logic [31:0]   fill_seed;

    function automatic logic [31:0] fill_word(input int k, input logic [31:0] seed);
        logic [31:0] kk;
        kk = k;
        return (kk * 32'h9E3779B1) ^ seed;
    endfunction

    always @(posedge clk) begin
        if (bd_fill) begin
            for (int k = 0; k < D; k++) mem[k] <= fill_word(k, fill_seed);
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (o_ram_we) begin
            mem[o_ram_addr] <= o_ram_wdata;
        end
        i_ram_rdata <= mem[o_ram_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_mem_all(input string nm);
        int mism;
        mism = 0;
        for (int k = 0; k < D; k++) begin
            if (mem[k] !== model_mem[k]) mism++;
        end
        chk({nm, "_mem_mismatches"}, 64'(mism), 64'd0);
    endtask

    task automatic fill(input logic [31:0] seed);
        @(negedge clk);
        fill_seed = seed;
        bd_fill   = 1'b1;
        @(negedge clk);
        bd_fill = 1'b0;
        for (int k = 0; k < D; k++) model_mem[k] = fill_word(k, seed);
    endtask

    task automatic bd_write(input int a, input logic [31:0] v);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = a[AL-1:0];
        bd_data = v;
        @(negedge clk);
        bd_we        = 1'b0;
        model_mem[a] = v;
    endtask

    // One copy: reference memmove on a snapshot, then run the DUT and compare timing, pulses and memory.
    task automatic do_copy(input string name, input int s, input int d, input int l,
                           input int pulse_at, input int exp_cyc, input int exp_we);
        int          eff, cyc, wes, busy_bad;
        logic [31:0] snap[$];
        logic [31:0] exp_sum;
        logic [31:0] sum_c1;
        logic [31:0] sum_done;
        eff     = (l > D) ? D : l;
        exp_sum = 32'd0;
        sum_c1  = 32'd0;
        sum_done = 32'd0;
        for (int i = 0; i < eff; i++) snap.push_back(model_mem[(s + i) % D]);
        for (int i = 0; i < eff; i++) begin
            model_mem[(d + i) % D] = snap[i];
            exp_sum = exp_sum + snap[i];
        end

        @(negedge clk);
        i_src   = s[AL-1:0];
        i_dst   = d[AL-1:0];
        i_len   = l[AL:0];
        i_start = 1'b1;
        @(negedge clk);
        i_start  = 1'b0;
        cyc      = 1;
        wes      = 0;
        busy_bad = 0;
`ifdef BLRAM_COPY_SUM_EN
        sum_c1 = o_sum;
`endif
        while (o_done !== 1'b1 && cyc < exp_cyc + 20) begin
            if (o_ram_we === 1'b1) wes++;
            if (o_busy !== 1'b1) busy_bad++;
            if (cyc == pulse_at) begin
                i_start = 1'b1;
                i_src   = 14'($urandom_range(0, D - 1));
                i_dst   = 14'($urandom_range(0, D - 1));
                i_len   = 15'($urandom_range(1, 40));
            end
            @(negedge clk);
            i_start = 1'b0;
            cyc++;
        end
        if (o_busy !== 1'b0) busy_bad++;
`ifdef BLRAM_COPY_SUM_EN
        sum_done = o_sum;
`endif
        chk({name, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
        chk({name, "_we_pulses"}, 64'(wes), 64'(exp_we));
        chk({name, "_busy_profile_errors"}, 64'(busy_bad), 64'd0);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, {63'd0, o_done}, 64'd0);
        chk_mem_all(name);
`ifdef BLRAM_COPY_SUM_EN
        chk({name, "_sum_cleared"}, {32'd0, sum_c1}, 64'd0);
        chk({name, "_sum"}, {32'd0, sum_done}, {32'd0, exp_sum});
`endif
    endtask

    typedef struct {
        int s;
        int d;
        int l;
        int pulse;
        int cyc;
        int we;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] exp_w [4];

    initial begin
        int seen, guard, bad, s, d, l, p, ec;
        logic [31:0] old0, old1;

        rst     = 1'b0;
        i_start = 1'b0;
        i_src   = '0;
        i_dst   = '0;
        i_len   = '0;
        bd_we   = 1'b0;
        bd_fill = 1'b0;
        bd_addr = '0;
        bd_data = 32'd0;
        fill_seed = 32'd0;

        vecs[0] = '{0, 100, 4, 0, 13, 4};
        vecs[1] = '{10, 12, 5, 0, 16, 5};
        vecs[2] = '{12, 10, 5, 0, 16, 5};
        vecs[3] = '{16382, 5, 4, 0, 13, 4};
        vecs[4] = '{50, 60, 0, 0, 1, 0};
        vecs[5] = '{200, 200, 3, 5, 10, 3};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {o_busy, o_done, o_ram_we, o_ram_addr, o_ram_wdata}, 64'd0);
`ifdef BLRAM_COPY_SUM_EN
        chk("reset_sum", {32'd0, o_sum}, 64'd0);
`endif
        rst = 1'b1;

        fill(32'h5A5A_1234);
        bd_write(0, 32'hAAAA0001);
        bd_write(1, 32'hBBBB0002);
        bd_write(2, 32'hCCCC0003);
        bd_write(3, 32'hDDDD0004);
        for (int k = 0; k < 5; k++) bd_write(10 + k, 32'(k + 1));
        bd_write(16382, 32'hEEEE0005);
        bd_write(16383, 32'hFFFF0006);

        for (int v = 0; v < 6; v++) begin
            do_copy($sformatf("vec%0d", v), vecs[v].s, vecs[v].d, vecs[v].l,
                    vecs[v].pulse, vecs[v].cyc, vecs[v].we);
        end

        // Hand-derived contents after the directed table.
        exp_w = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
        for (int k = 0; k < 4; k++) chk($sformatf("basic_dst%0d", k), {32'd0, mem[100 + k]}, {32'd0, exp_w[k]});
        for (int k = 0; k < 5; k++) chk($sformatf("overlap_back%0d", k), {32'd0, mem[10 + k]}, 64'(k + 1));
        chk("overlap_fwd15", {32'd0, mem[15]}, 64'd4);
        chk("overlap_fwd16", {32'd0, mem[16]}, 64'd5);
        exp_w = '{32'hEEEE0005, 32'hFFFF0006, 32'hAAAA0001, 32'hBBBB0002};
        for (int k = 0; k < 4; k++) chk($sformatf("wrap_dst%0d", k), {32'd0, mem[5 + k]}, {32'd0, exp_w[k]});

        // Reset after the second write of an 8-word ascending copy.
        old0 = model_mem[2000];
        old1 = model_mem[2001];
        @(negedge clk);
        i_src   = 14'd2000;
        i_dst   = 14'd1000;
        i_len   = 15'd8;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        seen    = 0;
        guard   = 0;
        while (seen < 2 && guard < 100) begin
            if (o_ram_we === 1'b1) seen++;
            if (seen < 2) begin
                @(negedge clk);
                guard++;
            end
        end
        chk("rst_wr_seen", 64'(seen), 64'd2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_outputs_now", {o_busy, o_done, o_ram_we, o_ram_addr, o_ram_wdata}, 64'd0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_done !== 1'b0 || o_ram_we !== 1'b0 || o_busy !== 1'b0) bad++;
        end
        chk("rst_quiet", 64'(bad), 64'd0);
        rst = 1'b1;
        model_mem[1000] = old0;
        model_mem[1001] = old1;
        chk_mem_all("rst_abort");
        do_copy("post_rst", 3000, 3100, 6, 0, 19, 6);

`ifdef BLRAM_COPY_SUM_EN
        bd_write(500, 32'd1);
        bd_write(501, 32'd2);
        bd_write(502, 32'hFFFFFFFF);
        do_copy("sum1", 500, 600, 3, 0, 10, 3);
        chk("sum_explicit", {32'd0, o_sum}, 64'd2);
        do_copy("sum2", 500, 700, 3, 4, 10, 3);
        chk("sum_explicit2", {32'd0, o_sum}, 64'd2);
`endif

        // Randomized copies, half of them with overlapping ranges, some with ignored busy-time starts.
        for (int r = 0; r < 20; r++) begin
            s = int'($urandom_range(100, 16000));
            if (r % 2 == 1) d = s + int'($urandom_range(0, 16)) - 8;
            else            d = int'($urandom_range(0, 16000));
            l  = int'($urandom_range(0, 48));
            p  = (l > 0) ? int'($urandom_range(1, 3 * l)) : 0;
            ec = (l == 0) ? 1 : 3 * l + 1;
            do_copy($sformatf("rand%0d", r), s, d, l, p, ec, l);
        end

        // Oversized length clamps to the full depth; src==dst leaves memory intact.
        do_copy("clamp", 1000, 1000, 20000, 0, 3 * D + 1, D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
